uart_tx_fifo: RTL and testbench

- Native UART transmitter with an input FIFO. Carries the packed result bytes from the packer back to the ESP over the serial line.
- Replaces the transmit half of the third-party UART core. Sits between the packer ready/valid output and the tx pin.
- Frame format is 8N1, LSB first. Bit timing uses the same prescale convention as the receive side: one bit lasts Fclk/(baud*8) × 8 clocks.

---
 rtl/uart_tx_fifo.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small ready/valid FIFO; UART_TX_PARITY_EN adds an even-parity bit (8E1).
// Latency: accept at edge E0 into an empty idle block -> start bit driven from E1; frames run back-to-back.
// Backpressure: ready_o = !full, derived from occupancy only (no same-cycle pop bypass).
module uart_tx_fifo #(
   parameter int data_width_p     = 8,
   parameter int fifo_depth_p     = 4,
   parameter int prescale_width_p = 16
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              valid_i,
   output logic                              ready_o,
   input  logic [data_width_p-1:0]           data_i,
   input  logic [prescale_width_p-1:0]       prescale_i,
   output logic                              tx_serial_o,
   output logic                              busy_o,
   output logic [$clog2(fifo_depth_p):0]     fifo_count_o
);

   localparam int addr_w = $clog2(fifo_depth_p);
   localparam int idx_w  = (data_width_p > 1) ? $clog2(data_width_p) : 1;
   localparam int tmr_w  = prescale_width_p + 3;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   // ---------------- input FIFO ----------------
   logic [data_width_p-1:0] mem [fifo_depth_p];
   logic [addr_w:0]         wr_ptr_q, rd_ptr_q;
   logic                    full, empty, push, pop;
   logic [data_width_p-1:0] head;

   assign fifo_count_o = wr_ptr_q - rd_ptr_q;
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign full         = (fifo_count_o == (addr_w+1)'(fifo_depth_p));
   assign ready_o      = !full;
   assign push         = valid_i && ready_o;
   assign head         = mem[rd_ptr_q[addr_w-1:0]];

   always_ff @(posedge clk_i) begin
      if (push)
         mem[wr_ptr_q[addr_w-1:0]] <= data_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // ---------------- transmit FSM ----------------
   state_t                      state_q, state_n;
   logic [data_width_p-1:0]     shift_q;
   logic [prescale_width_p-1:0] presc_q;
   logic [tmr_w-1:0]            bit_cnt_q, period_m1;
   logic [idx_w-1:0]            bit_idx_q;
   logic                        parity_q;
   logic                        tx_q, tx_n;
   logic                        bit_end, last_bit;
   logic                        load, shift_en, bit_rst;

   // Bit period is 8*prescale clocks, so the terminal count is {prescale-1, 3'b111}.
   assign period_m1 = {presc_q - 1'b1, 3'b111};
   assign bit_end   = (bit_cnt_q == period_m1);
   assign last_bit  = (bit_idx_q == idx_w'(data_width_p - 1));

   always_comb begin
      state_n  = state_q;
      tx_n     = tx_q;
      pop      = 1'b0;
      load     = 1'b0;
      shift_en = 1'b0;
      bit_rst  = 1'b0;
      case (state_q)
         IDLE: begin
            tx_n = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               load    = 1'b1;
               state_n = START;
               tx_n    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               bit_rst = 1'b1;
               state_n = DATA;
               tx_n    = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               bit_rst  = 1'b1;
               shift_en = 1'b1;
               if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
                  tx_n    = parity_q;
`else
                  state_n = STOP;
                  tx_n    = 1'b1;
`endif
               end else begin
                  tx_n = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               bit_rst = 1'b1;
               state_n = STOP;
               tx_n    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               bit_rst = 1'b1;
               // Back-to-back: next start bit follows the stop bit with no idle gap.
               if (!empty) begin
                  pop     = 1'b1;
                  load    = 1'b1;
                  state_n = START;
                  tx_n    = 1'b0;
               end else begin
                  state_n = IDLE;
                  tx_n    = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         tx_q      <= 1'b1;
         shift_q   <= '0;
         presc_q   <= prescale_width_p'(1);
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
         parity_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         tx_q    <= tx_n;
         if (load) begin
            shift_q   <= head;
            parity_q  <= ^head;
            presc_q   <= (prescale_i == '0) ? prescale_width_p'(1) : prescale_i;
            bit_idx_q <= '0;
         end else if (shift_en) begin
            shift_q   <= {1'b0, shift_q[data_width_p-1:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
         end
         if (load || bit_rst || state_q == IDLE)
            bit_cnt_q <= '0;
         else
            bit_cnt_q <= bit_cnt_q + 1'b1;
      end
   end

   assign tx_serial_o = tx_q;
   assign busy_o      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: drives and samples on the falling edge, checks frames bit by bit.
module tb_uart_tx_fifo;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [7:0]  data_i = 8'h00;
   logic [15:0] prescale_i = 16'd1;
   logic        tx_serial_o;
   logic        busy_o;
   logic [2:0]  fifo_count_o;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef UART_TX_PARITY_EN
   localparam int nb_c = 11;
`else
   localparam int nb_c = 10;
`endif

   uart_tx_fifo #(.data_width_p(8), .fifo_depth_p(4), .prescale_width_p(16)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_i(data_i), .prescale_i(prescale_i), .tx_serial_o(tx_serial_o),
      .busy_o(busy_o), .fifo_count_o(fifo_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Called at the falling edge of the first start-bit clock; returns at the last stop-bit clock.
   task automatic check_frame(input logic [7:0] b, input int p, input string tag);
      logic exp_bits [11];
      logic first, last;
      exp_bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) exp_bits[k+1] = b[k];
`ifdef UART_TX_PARITY_EN
      exp_bits[9]  = ^b;
      exp_bits[10] = 1'b1;
`else
      exp_bits[9]  = 1'b1;
      exp_bits[10] = 1'b1;
`endif
      for (int i = 0; i < nb_c; i++) begin
         first = 1'b0;
         last  = 1'b0;
         for (int c = 0; c < p; c++) begin
            if (c == 0)     first = tx_serial_o;
            if (c == p - 1) last  = tx_serial_o;
            if (!(i == nb_c - 1 && c == p - 1)) @(negedge clk_i);
         end
         check($sformatf("%s_bit%0d", tag, i), {30'd0, first, last}, {30'd0, exp_bits[i], exp_bits[i]});
      end
   endtask

   task automatic wait_start(input string tag);
      int k = 0;
      while (tx_serial_o !== 1'b0 && k < 2000) begin
         @(negedge clk_i);
         k++;
      end
      check({tag, "_start"}, tx_serial_o, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int lows;
      // ---- reset state ----
      repeat (3) @(negedge clk_i);
      check("rst_tx", tx_serial_o, 1);
      check("rst_ready", ready_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_count", fifo_count_o, 0);
      reset_i = 1'b0;
      @(negedge clk_i);

      // ---- 1: single frame 0xA5, prescale 1 ----
      valid_i = 1'b1; data_i = 8'hA5;
      @(negedge clk_i);
      valid_i = 1'b0;
      check("t1_tx_before_pop", tx_serial_o, 1);
      check("t1_count_after_push", fifo_count_o, 1);
      @(negedge clk_i);
      check("t1_count_after_pop", fifo_count_o, 0);
      check("t1_busy", busy_o, 1);
      check_frame(8'hA5, 8, "t1");
      check("t1_busy_in_stop", busy_o, 1);
      @(negedge clk_i);
      check("t1_busy_done", busy_o, 0);
      check("t1_tx_idle", tx_serial_o, 1);

      // ---- 2: six bytes, prescale 2, backpressure and back-to-back ----
      prescale_i = 16'd2;
      @(negedge clk_i);
      fork
         begin
            valid_i = 1'b1;
            for (int i = 0; i < 5; i++) begin
               data_i = 8'(i);
               @(negedge clk_i);
            end
            check("t2_count_full", fifo_count_o, 4);
            check("t2_ready_full", ready_o, 0);
            data_i = 8'h05;
            k = 0;
            while (!ready_o && k < 400) begin
               @(negedge clk_i);
               k++;
            end
            check("t2_ready_low_cycles", k, 157);
            @(negedge clk_i);
            valid_i = 1'b0;
            check("t2_count_refill", fifo_count_o, 4);
            check("t2_ready_refill", ready_o, 0);
         end
         begin
            wait_start("t2");
            for (int j = 0; j < 6; j++) begin
               check_frame(8'(j), 16, $sformatf("t2_f%0d", j));
               if (j < 5) @(negedge clk_i);
            end
            @(negedge clk_i);
            check("t2_busy_done", busy_o, 0);
            check("t2_count_done", fifo_count_o, 0);
         end
      join

      // ---- 3: reset mid-DATA with two bytes queued ----
      prescale_i = 16'd1;
      @(negedge clk_i);
      valid_i = 1'b1; data_i = 8'h3C;
      @(negedge clk_i); data_i = 8'h11;
      @(negedge clk_i); data_i = 8'h22;
      @(negedge clk_i); valid_i = 1'b0;
      repeat (19) @(negedge clk_i);
      check("t3_tx_data_bit1", tx_serial_o, 0);
      check("t3_count_queued", fifo_count_o, 2);
      reset_i = 1'b1;
      #1;
      check("t3_tx_reset", tx_serial_o, 1);
      check("t3_ready_reset", ready_o, 1);
      check("t3_count_reset", fifo_count_o, 0);
      check("t3_busy_reset", busy_o, 0);
      @(negedge clk_i);
      reset_i = 1'b0;
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_i);
         if (tx_serial_o !== 1'b1) lows++;
      end
      check("t3_no_frames", lows, 0);
      check("t3_busy_after", busy_o, 0);

      // ---- 4: prescale change mid-frame ----
      valid_i = 1'b1; data_i = 8'h5A;
      @(negedge clk_i); data_i = 8'h96;
      @(negedge clk_i); valid_i = 1'b0;
      fork
         begin
            repeat (12) @(negedge clk_i);
            prescale_i = 16'd3;
         end
         check_frame(8'h5A, 8, "t4a");
      join
      @(negedge clk_i);
      check_frame(8'h96, 24, "t4b");
      @(negedge clk_i);
      check("t4_busy_done", busy_o, 0);

      // ---- 5: prescale 0 behaves as 1 ----
      prescale_i = 16'd0;
      valid_i = 1'b1; data_i = 8'hFF;
      @(negedge clk_i);
      valid_i = 1'b0;
      check("t5_tx_before_pop", tx_serial_o, 1);
      @(negedge clk_i);
      check_frame(8'hFF, 8, "t5");
      @(negedge clk_i);
      check("t5_busy_done", busy_o, 0);

      // ---- 6: 0x07 then 0x03 (parity bits 1 and 0 when enabled) ----
      prescale_i = 16'd1;
      valid_i = 1'b1; data_i = 8'h07;
      @(negedge clk_i); data_i = 8'h03;
      @(negedge clk_i); valid_i = 1'b0;
      check_frame(8'h07, 8, "t6a");
      @(negedge clk_i);
      check_frame(8'h03, 8, "t6b");
      @(negedge clk_i);
      check("t6_busy_done", busy_o, 0);
      check("t6_tx_idle", tx_serial_o, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
